// File: rtl/freq_ratio_meter.sv
// -----------------------------------------------------------------------------
// freq_ratio_meter
//
// Measures the period and high time of a slow, asynchronous periodic signal
// in units of the system clock, and reports when the period has been stable
// for LOCK_CNT consecutive measurements.
//
// Parameters
//   CW        measurement counter width in bits
//   LOCK_CNT  consecutive equal periods needed for lock (2..15)
//
// Ports
//   clk        system clock, rising edge only
//   rst        synchronous active-high reset
//   sig_in     asynchronous slow periodic input
//   period_out clk cycles between the last two rising edges of sig_in
//   high_out   clk cycles sig_in was high within that period
//   valid      one-cycle pulse when period_out/high_out update
//   locked     LOCK_CNT consecutive measurements had the same period
//   timeout    sticky: no sig_in edge within 2^CW-1 cycles
// -----------------------------------------------------------------------------
module freq_ratio_meter #(
    parameter int CW       = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    output logic [CW-1:0] period_out,
    output logic [CW-1:0] high_out,
    output logic          valid,
    output logic          locked,
    output logic          timeout
);

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    LOCK_THR = 4'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic          sync1_r;
    logic          sync2_r;
    logic          hist_r;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] high_cap_r;
    logic [CW-1:0] period_r;
    logic [CW-1:0] high_r;
    logic          valid_r;
    logic          locked_r;
    logic          timeout_r;
    logic          prev_ok_r;   // period_r holds a comparable previous period
    logic [3:0]    match_r;

    logic          rise_det_s;
    logic          fall_det_s;
    logic          sat_s;
    logic          same_s;
    logic [CW-1:0] cnt_inc_s;
    logic [3:0]    match_next_s;

    // Edge detection, saturation and lock-match arithmetic.
    always_comb begin
        rise_det_s = sync2_r & ~hist_r;
        fall_det_s = ~sync2_r & hist_r;
        sat_s      = (cnt_r == CNT_MAX);
        cnt_inc_s  = sat_s ? cnt_r : (cnt_r + CNT_ONE);
        same_s     = prev_ok_r && (cnt_r == period_r);
        if (same_s) begin
            if (match_r == 4'hF) begin
                match_next_s = match_r;
            end else begin
                match_next_s = match_r + 4'd1;
            end
        end else begin
            match_next_s = 4'd0;
        end
    end

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Measurement FSM with registered outputs and lock tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            high_cap_r <= '0;
            period_r   <= '0;
            high_r     <= '0;
            valid_r    <= 1'b0;
            locked_r   <= 1'b0;
            timeout_r  <= 1'b0;
            prev_ok_r  <= 1'b0;
            match_r    <= 4'd0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A fall here is meaningless: no measurement is running.
                    if (rise_det_s) begin
                        state_r   <= HIGH;
                        cnt_r     <= CNT_ONE;
                        timeout_r <= 1'b0;
                    end
                end
                HIGH: begin
                    // Saturation is checked first so it wins over any edge.
                    if (sat_s) begin
                        timeout_r <= 1'b1;
                        locked_r  <= 1'b0;
                        match_r   <= 4'd0;
                        prev_ok_r <= 1'b0;
                        state_r   <= IDLE;
                    end else if (fall_det_s) begin
                        high_cap_r <= cnt_r;
                        cnt_r      <= cnt_inc_s;
                        state_r    <= LOW;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                LOW: begin
                    if (sat_s) begin
                        timeout_r <= 1'b1;
                        locked_r  <= 1'b0;
                        match_r   <= 4'd0;
                        prev_ok_r <= 1'b0;
                        state_r   <= IDLE;
                    end else if (rise_det_s) begin
                        period_r  <= cnt_r;
                        high_r    <= high_cap_r;
                        valid_r   <= 1'b1;
                        cnt_r     <= CNT_ONE;
                        state_r   <= HIGH;
                        prev_ok_r <= 1'b1;
                        match_r   <= match_next_s;
                        locked_r  <= (match_next_s >= LOCK_THR);
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign period_out = period_r;
    assign high_out   = high_r;
    assign valid      = valid_r;
    assign locked     = locked_r;
    assign timeout    = timeout_r;

endmodule
